m_axi_lite_master: RTL and testbench

M_AXI_LITE_MASTER -- requirements
Module: m_axi_lite_master

---
 rtl/axi_lite_pkg.sv | 21 ++
 rtl/m_axi_lite_master.sv | 167 ++++++++++++++++
 tb/tb_m_axi_lite_master.sv | 432 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite definitions: master FSM state encoding and
// response codes, common to the master and the slave benches.
package axi_lite_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_WRESP = 3'd2,
        ST_RADDR = 3'd3,
        ST_RDATA = 3'd4,
        ST_RSP   = 3'd5
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [2:0] PROT_DEFAULT = 3'b000;

endpackage

// File: rtl/m_axi_lite_master.sv
// AXI4-Lite single-outstanding master: turns a simple cmd/rsp
// handshake into one AXI read or write transaction.
// Ports: cmd_* (command in), rsp_* (response out), M_AXI_* (AXI4-Lite
// master channels AW/W/B/AR/R), M_AXI_ACLK / M_AXI_ARESETn (async low).
module m_axi_lite_master
    import axi_lite_pkg::*;
#(
    parameter int C_M_AXI_ADDR_WIDTH = 32,
    parameter int C_M_AXI_DATA_WIDTH = 32
) (
    input  logic                            M_AXI_ACLK,
    input  logic                            M_AXI_ARESETn,
    input  logic                            cmd_valid,
    output logic                            cmd_ready,
    input  logic                            cmd_write,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [C_M_AXI_DATA_WIDTH/8-1:0] cmd_wstrb,
    output logic                            rsp_valid,
    input  logic                            rsp_ready,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]                      rsp_resp,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
    output logic [2:0]                      M_AXI_AWPROT,
    output logic                            M_AXI_AWVALID,
    input  logic                            M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
    output logic                            M_AXI_WVALID,
    input  logic                            M_AXI_WREADY,
    input  logic [1:0]                      M_AXI_BRESP,
    input  logic                            M_AXI_BVALID,
    output logic                            M_AXI_BREADY,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
    output logic [2:0]                      M_AXI_ARPROT,
    output logic                            M_AXI_ARVALID,
    input  logic                            M_AXI_ARREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
    input  logic [1:0]                      M_AXI_RRESP,
    input  logic                            M_AXI_RVALID,
    output logic                            M_AXI_RREADY
);

    state_t                            r_state;
    logic                              r_cmd_ready;
    logic                              r_awvalid;
    logic                              r_wvalid;
    logic                              r_bready;
    logic                              r_arvalid;
    logic                              r_rready;
    logic                              r_rsp_valid;
    logic [C_M_AXI_ADDR_WIDTH-1:0]     r_addr;
    logic [C_M_AXI_DATA_WIDTH-1:0]     r_wdata;
    logic [C_M_AXI_DATA_WIDTH/8-1:0]   r_wstrb;
    logic [C_M_AXI_DATA_WIDTH-1:0]     r_rdata;
    logic [1:0]                        r_resp;

    logic w_aw_hs;
    logic w_w_hs;
    logic w_aw_done;
    logic w_w_done;

    assign w_aw_hs   = r_awvalid && M_AXI_AWREADY;
    assign w_w_hs    = r_wvalid && M_AXI_WREADY;
    // A channel is finished if its valid already dropped or it
    // completes on this edge; AW and W may finish in any order.
    assign w_aw_done = !r_awvalid || w_aw_hs;
    assign w_w_done  = !r_wvalid || w_w_hs;

    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETn) begin
        if (!M_AXI_ARESETn) begin
            r_state     <= ST_IDLE;
            r_cmd_ready <= 1'b0;
            r_awvalid   <= 1'b0;
            r_wvalid    <= 1'b0;
            r_bready    <= 1'b0;
            r_arvalid   <= 1'b0;
            r_rready    <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_wstrb     <= '0;
            r_rdata     <= '0;
            r_resp      <= RESP_OKAY;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    r_cmd_ready <= 1'b1;
                    if (cmd_valid && r_cmd_ready) begin
                        r_cmd_ready <= 1'b0;
                        r_addr      <= cmd_addr;
                        r_wdata     <= cmd_wdata;
                        r_wstrb     <= cmd_wstrb;
                        if (cmd_write) begin
                            r_awvalid <= 1'b1;
                            r_wvalid  <= 1'b1;
                            r_state   <= ST_WRITE;
                        end else begin
                            r_arvalid <= 1'b1;
                            r_state   <= ST_RADDR;
                        end
                    end
                end
                ST_WRITE: begin
                    if (w_aw_hs) r_awvalid <= 1'b0;
                    if (w_w_hs)  r_wvalid  <= 1'b0;
                    if (w_aw_done && w_w_done) begin
                        r_bready <= 1'b1;
                        r_state  <= ST_WRESP;
                    end
                end
                ST_WRESP: begin
                    if (M_AXI_BVALID) begin
                        r_bready    <= 1'b0;
                        r_resp      <= M_AXI_BRESP;
                        r_rdata     <= '0;
                        r_rsp_valid <= 1'b1;
                        r_state     <= ST_RSP;
                    end
                end
                ST_RADDR: begin
                    if (M_AXI_ARREADY) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_state   <= ST_RDATA;
                    end
                end
                ST_RDATA: begin
                    if (M_AXI_RVALID) begin
                        r_rready    <= 1'b0;
                        r_rdata     <= M_AXI_RDATA;
                        r_resp      <= M_AXI_RRESP;
                        r_rsp_valid <= 1'b1;
                        r_state     <= ST_RSP;
                    end
                end
                ST_RSP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_cmd_ready <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready     = r_cmd_ready;
    assign rsp_valid     = r_rsp_valid;
    assign rsp_rdata     = r_rdata;
    assign rsp_resp      = r_resp;
    assign M_AXI_AWADDR  = r_addr;
    assign M_AXI_AWPROT  = PROT_DEFAULT;
    assign M_AXI_AWVALID = r_awvalid;
    assign M_AXI_WDATA   = r_wdata;
    assign M_AXI_WSTRB   = r_wstrb;
    assign M_AXI_WVALID  = r_wvalid;
    assign M_AXI_BREADY  = r_bready;
    assign M_AXI_ARADDR  = r_addr;
    assign M_AXI_ARPROT  = PROT_DEFAULT;
    assign M_AXI_ARVALID = r_arvalid;
    assign M_AXI_RREADY  = r_rready;

endmodule

// File: tb/tb_m_axi_lite_master.sv
// Directed bench for m_axi_lite_master against a small AXI4-Lite
// memory slave with programmable ready delays and responses.
module tb_m_axi_lite_master;
    import axi_lite_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
    logic [31:0] cmd_addr = '0, cmd_wdata = '0;
    logic [3:0]  cmd_wstrb = '0;
    logic        rsp_valid, rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [2:0]  awprot, arprot;
    logic [3:0]  wstrb;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [1:0]  bresp, rresp;

    int          errs = 0, checks = 0;

    // slave knobs
    int          aw_delay = 0, w_delay = 0;
    logic        b_block = 1'b0;
    logic [1:0]  bresp_val = RESP_OKAY, rresp_val = RESP_OKAY;
    logic        rd_ovr_en = 1'b0;
    logic [31:0] rd_ovr = '0;

    always #5 clk = ~clk;

    m_axi_lite_master dut (
        .M_AXI_ACLK(clk), .M_AXI_ARESETn(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_write(cmd_write), .cmd_addr(cmd_addr),
        .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .M_AXI_AWADDR(awaddr), .M_AXI_AWPROT(awprot),
        .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
        .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb),
        .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
        .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid),
        .M_AXI_BREADY(bready),
        .M_AXI_ARADDR(araddr), .M_AXI_ARPROT(arprot),
        .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
        .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp),
        .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
    );

    // ---------------- slave model ----------------
    logic [31:0] mem [64];
    int          aw_cnt, w_cnt;
    logic        aw_got, w_got;
    logic [31:0] aw_a, w_d;
    logic [3:0]  w_s;
    logic        aw_ok, w_ok;
    logic [31:0] s_addr, s_data;
    logic [3:0]  s_strb;

    assign awready = awvalid && (aw_cnt >= aw_delay);
    assign wready  = wvalid && (w_cnt >= w_delay);
    assign arready = arvalid;
    assign aw_ok   = aw_got || (awvalid && awready);
    assign w_ok    = w_got || (wvalid && wready);
    assign s_addr  = aw_got ? aw_a : awaddr;
    assign s_data  = w_got ? w_d : wdata;
    assign s_strb  = w_got ? w_s : wstrb;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_cnt <= 0; w_cnt <= 0;
            aw_got <= 1'b0; w_got <= 1'b0;
            aw_a <= '0; w_d <= '0; w_s <= '0;
            bvalid <= 1'b0; bresp <= '0;
            rvalid <= 1'b0; rdata <= '0; rresp <= '0;
            for (int i = 0; i < 64; i++) mem[i] <= '0;
        end else begin
            aw_cnt <= (awvalid && !awready) ? aw_cnt + 1 : 0;
            w_cnt  <= (wvalid && !wready) ? w_cnt + 1 : 0;
            if (awvalid && awready) begin
                aw_got <= 1'b1; aw_a <= awaddr;
            end
            if (wvalid && wready) begin
                w_got <= 1'b1; w_d <= wdata; w_s <= wstrb;
            end
            if (aw_ok && w_ok && !bvalid && !b_block) begin
                for (int b = 0; b < 4; b++)
                    if (s_strb[b])
                        mem[s_addr[7:2]][b*8 +: 8] <= s_data[b*8 +: 8];
                bvalid <= 1'b1;
                bresp  <= bresp_val;
                aw_got <= 1'b0;
                w_got  <= 1'b0;
            end
            if (bvalid && bready) bvalid <= 1'b0;
            if (arvalid && arready) begin
                rvalid <= 1'b1;
                rdata  <= rd_ovr_en ? rd_ovr : mem[araddr[7:2]];
                rresp  <= rresp_val;
            end else if (rvalid && rready) begin
                rvalid <= 1'b0;
            end
        end
    end

    // ---------------- event counters ----------------
    int acc_cnt = 0, aw_hs = 0, w_hs = 0, b_hs = 0;
    int aw_only = 0, w_only = 0;

    always @(posedge clk) begin
        if (cmd_valid && cmd_ready) acc_cnt++;
        if (awvalid && awready) aw_hs++;
        if (wvalid && wready) w_hs++;
        if (bvalid && bready) b_hs++;
    end

    always @(negedge clk) begin
        if (!awvalid && wvalid) w_only++;
        if (awvalid && !wvalid) aw_only++;
    end

    // ---------------- command driver ----------------
    task automatic issue(
        input  logic        w,
        input  logic [31:0] a,
        input  logic [31:0] d,
        input  logic [3:0]  s,
        input  int          hold,
        output logic [31:0] rd,
        output logic [1:0]  rs,
        output int          lat,
        output bit          stable,
        output bit          rdy_after,
        output bit          to
    );
        int n;
        rd = 'x; rs = 'x; lat = 0;
        stable = 1'b1; rdy_after = 1'b0; to = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a;
        cmd_wdata = d; cmd_wstrb = s; rsp_ready = 1'b0;
        n = 0;
        while (!cmd_ready && n < 100) begin
            @(negedge clk); n++;
        end
        if (!cmd_ready) begin
            cmd_valid = 1'b0; to = 1'b1;
            return;
        end
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        n = 0;
        do begin
            @(negedge clk); n++;
        end while (!rsp_valid && n < 200);
        if (!rsp_valid) begin
            to = 1'b1;
            return;
        end
        lat = n; rd = rsp_rdata; rs = rsp_resp;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (!rsp_valid || rsp_rdata !== rd || rsp_resp !== rs)
                stable = 1'b0;
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        rdy_after = cmd_ready && !rsp_valid;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        #12;
        checks++;
        if ({cmd_ready, rsp_valid, awvalid, wvalid, bready,
             arvalid, rready} !== 7'b0) begin
            errs++;
            $display("FAIL reset_ctrl: got %b exp 0000000",
                {cmd_ready, rsp_valid, awvalid, wvalid, bready,
                 arvalid, rready});
        end
        checks++;
        if (awaddr !== 32'h0 || wdata !== 32'h0 || wstrb !== 4'h0 ||
            rsp_rdata !== 32'h0 || rsp_resp !== 2'b00) begin
            errs++;
            $display("FAIL reset_regs: addr %h wdata %h strb %h rd %h rs %b exp 0",
                awaddr, wdata, wstrb, rsp_rdata, rsp_resp);
        end
        checks++;
        if (awprot !== 3'b000 || arprot !== 3'b000) begin
            errs++;
            $display("FAIL prot: aw %b ar %b exp 000", awprot, arprot);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (cmd_ready !== 1'b1) begin
            errs++;
            $display("FAIL reset_release_rdy: got %b exp 1", cmd_ready);
        end
    endtask

    task automatic test_write_basic();
        logic [31:0] rd; logic [1:0] rs; int lat; bit st, ra, to;
        int aw0, w0, awo0, wo0;
        aw0 = aw_hs; w0 = w_hs; awo0 = aw_only; wo0 = w_only;
        issue(1'b1, 32'h04, 32'h0000_00A5, 4'hF, 0, rd, rs, lat, st, ra, to);
        checks++;
        if (to || rs !== RESP_OKAY || rd !== 32'h0) begin
            errs++;
            $display("FAIL wr_basic_rsp: to %0d resp %b rdata %h exp 00/0", to, rs, rd);
        end
        checks++;
        if (lat !== 3) begin
            errs++;
            $display("FAIL wr_latency: got %0d exp 3", lat);
        end
        checks++;
        if (aw_hs - aw0 != 1 || w_hs - w0 != 1 ||
            aw_only != awo0 || w_only != wo0) begin
            errs++;
            $display("FAIL wr_same_cycle: aw %0d w %0d awo %0d wo %0d exp 1 1 0 0",
                aw_hs - aw0, w_hs - w0, aw_only - awo0, w_only - wo0);
        end
        checks++;
        if (mem[1] !== 32'h0000_00A5) begin
            errs++;
            $display("FAIL wr_mem: got %h exp 000000a5", mem[1]);
        end
        checks++;
        if (!ra) begin
            errs++;
            $display("FAIL wr_rdy_after: got 0 exp 1");
        end
    endtask

    task automatic test_read_hold();
        logic [31:0] rd; logic [1:0] rs; int lat; bit st, ra, to;
        issue(1'b0, 32'h04, 32'h0, 4'h0, 5, rd, rs, lat, st, ra, to);
        checks++;
        if (to || rd !== 32'h0000_00A5 || rs !== RESP_OKAY) begin
            errs++;
            $display("FAIL rd_basic: to %0d rdata %h resp %b exp 000000a5/00", to, rd, rs);
        end
        checks++;
        if (!st) begin
            errs++;
            $display("FAIL rd_hold: rsp not stable over 5 cycles, exp stable");
        end
        checks++;
        if (lat !== 3) begin
            errs++;
            $display("FAIL rd_latency: got %0d exp 3", lat);
        end
    endtask

    task automatic test_strobe();
        logic [31:0] rd; logic [1:0] rs; int lat; bit st, ra, to;
        issue(1'b1, 32'h08, 32'h1122_3344, 4'hF, 0, rd, rs, lat, st, ra, to);
        issue(1'b1, 32'h08, 32'hAABB_CCDD, 4'h5, 0, rd, rs, lat, st, ra, to);
        issue(1'b0, 32'h08, 32'h0, 4'h0, 0, rd, rs, lat, st, ra, to);
        checks++;
        if (to || rd !== 32'h11BB_33DD) begin
            errs++;
            $display("FAIL strobe: to %0d got %h exp 11bb33dd", to, rd);
        end
    endtask

    task automatic test_split(input int awd, input int wd);
        logic [31:0] rd; logic [1:0] rs; int lat; bit st, ra, to;
        int aw0, w0, b0, awo0, wo0;
        aw0 = aw_hs; w0 = w_hs; b0 = b_hs; awo0 = aw_only; wo0 = w_only;
        aw_delay = awd; w_delay = wd;
        issue(1'b1, 32'h0C, 32'hCAFE_0000 | awd, 4'hF, 0, rd, rs, lat, st, ra, to);
        aw_delay = 0; w_delay = 0;
        checks++;
        if (to || aw_hs - aw0 != 1 || w_hs - w0 != 1 || b_hs - b0 != 1) begin
            errs++;
            $display("FAIL split_hs(%0d,%0d): to %0d aw %0d w %0d b %0d exp 1 1 1",
                awd, wd, to, aw_hs - aw0, w_hs - w0, b_hs - b0);
        end
        checks++;
        if (awd < wd ? (w_only - wo0 != wd - awd || aw_only != awo0)
                     : (aw_only - awo0 != awd - wd || w_only != wo0)) begin
            errs++;
            $display("FAIL split_drop(%0d,%0d): w_only %0d aw_only %0d exp %0d",
                awd, wd, w_only - wo0, aw_only - awo0,
                awd < wd ? wd - awd : awd - wd);
        end
        checks++;
        if (mem[3] !== (32'hCAFE_0000 | awd)) begin
            errs++;
            $display("FAIL split_mem(%0d,%0d): got %h exp %h",
                awd, wd, mem[3], 32'hCAFE_0000 | awd);
        end
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic [1:0] rs; int lat; bit st, ra, to;
        rresp_val = RESP_SLVERR; rd_ovr_en = 1'b1; rd_ovr = 32'hDEAD_BEEF;
        issue(1'b0, 32'hFC, 32'h0, 4'h0, 0, rd, rs, lat, st, ra, to);
        rresp_val = RESP_OKAY; rd_ovr_en = 1'b0;
        checks++;
        if (to || rs !== 2'b10 || rd !== 32'hDEAD_BEEF) begin
            errs++;
            $display("FAIL rd_slverr: to %0d resp %b rdata %h exp 10/deadbeef", to, rs, rd);
        end
        bresp_val = RESP_DECERR;
        issue(1'b1, 32'h20, 32'h1234_5678, 4'hF, 0, rd, rs, lat, st, ra, to);
        bresp_val = RESP_OKAY;
        checks++;
        if (to || rs !== 2'b11 || rd !== 32'h0) begin
            errs++;
            $display("FAIL wr_decerr: to %0d resp %b rdata %h exp 11/0", to, rs, rd);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd; logic [1:0] rs; int lat; bit st, ra, to;
        logic [31:0] shadow [16];
        logic [31:0] addrs [16];
        logic [31:0] d;
        int a0, nto;
        for (int i = 0; i < 16; i++) shadow[i] = '0;
        a0 = acc_cnt; nto = 0;
        for (int i = 0; i < 16; i++) begin
            addrs[i] = 32'h80 + 4 * $urandom_range(0, 15);
            d = $urandom;
            issue(1'b1, addrs[i], d, 4'hF, 0, rd, rs, lat, st, ra, to);
            if (to) nto++;
            shadow[(addrs[i] - 32'h80) >> 2] = d;
        end
        for (int i = 0; i < 16; i++) begin
            issue(1'b0, addrs[i], 32'h0, 4'h0, 0, rd, rs, lat, st, ra, to);
            checks++;
            if (to || rd !== shadow[(addrs[i] - 32'h80) >> 2]) begin
                errs++;
                $display("FAIL b2b_rd[%0d]: addr %h got %h exp %h",
                    i, addrs[i], rd, shadow[(addrs[i] - 32'h80) >> 2]);
            end
        end
        checks++;
        if (acc_cnt - a0 != 32 || nto != 0) begin
            errs++;
            $display("FAIL b2b_accepts: got %0d (wr timeouts %0d) exp 32",
                acc_cnt - a0, nto);
        end
    endtask

    task automatic test_reset_midflight();
        int n;
        bit seen;
        b_block = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h10;
        cmd_wdata = 32'h5555_AAAA; cmd_wstrb = 4'hF;
        n = 0;
        while (!cmd_ready && n < 20) begin
            @(negedge clk); n++;
        end
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        n = 0;
        while (!bready && n < 20) begin
            @(negedge clk); n++;
        end
        checks++;
        if (bready !== 1'b1) begin
            errs++;
            $display("FAIL rst_mid_wresp: bready %b exp 1", bready);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({awvalid, wvalid, bready, rsp_valid, cmd_ready} !== 5'b0) begin
            errs++;
            $display("FAIL rst_mid_drop: got %b exp 00000",
                {awvalid, wvalid, bready, rsp_valid, cmd_ready});
        end
        @(negedge clk);
        b_block = 1'b0;
        rst_n = 1'b1;
        #1;
        checks++;
        if (cmd_ready !== 1'b0) begin
            errs++;
            $display("FAIL rst_mid_rdy_early: got %b exp 0", cmd_ready);
        end
        @(posedge clk);
        #1;
        checks++;
        if (cmd_ready !== 1'b1) begin
            errs++;
            $display("FAIL rst_mid_rdy: got %b exp 1", cmd_ready);
        end
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (rsp_valid || awvalid || wvalid) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errs++;
            $display("FAIL rst_mid_discard: got activity 1 exp 0");
        end
    endtask

    initial begin
        test_reset();
        test_write_basic();
        test_read_hold();
        test_strobe();
        test_split(1, 4);
        test_split(4, 1);
        test_errors();
        test_back_to_back();
        test_reset_midflight();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: sim time limit reached");
        $fatal(1);
    end

endmodule
